cnn_mac_acc_sat: RTL

- Downstream consumer of the signed 14x8 conv multiplier in the W14_6 datapath.
- Accepts a stream of 23-bit signed products, one per beat, and accumulates them over one kernel window delimited by `s_last`. The bias is pre-loaded on the first beat.
- At window end it rounds, saturates and optionally applies ReLU, then emits one 14-bit activation in the same fixed-point format as the multiplier's `din0` (Q6.8).
- Valid/ready handshake on both sides; single output register stage.

---
 rtl/cnn_mac_acc_sat.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cnn_mac_acc_sat.sv
// cnn_mac_acc_sat: accumulates a window of signed conv products (bias pre-loaded
// on the first beat), then rounds, saturates and optionally ReLUs the sum into
// a Q6.8 activation held in a single output register with valid/ready.
module cnn_mac_acc_sat #(
    parameter int PROD_W  = 23,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 14,
    parameter int SHIFT   = 6,
    parameter int RELU_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] s_prod,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [OUT_W-1:0]  bias,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              sat_flag
);

    typedef enum logic {ST_FIRST, ST_ACCUM} state_t;

    // Rounding constant and output clip limits, carried one bit wider than the
    // accumulator so that adding the half-LSB can never wrap.
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(2**(SHIFT-1));
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]         m_data_q, m_data_d;
    logic                     m_valid_q, m_valid_d;
    logic                     sat_q, sat_d;

    logic                     accept;
    logic signed [ACC_W-1:0]  bias_al, prod_ext, base, sum;
    logic signed [ACC_W:0]    sum_x, rnd;
    logic [OUT_W-1:0]         sat_val, out_val;
    logic                     clip;

    assign s_ready  = !(m_valid_q && !m_ready);
    assign accept   = s_valid && s_ready;

    // Bias is in output format; shift it up to the product's fractional point.
    assign bias_al  = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias} <<< SHIFT;
    assign prod_ext = {{(ACC_W-PROD_W){s_prod[PROD_W-1]}}, s_prod};
    assign base     = (state_q == ST_FIRST) ? bias_al : acc_q;
    assign sum      = base + prod_ext;

    // Round half up, then arithmetic shift back to the output fraction.
    assign sum_x    = {sum[ACC_W-1], sum} + HALF;
    assign rnd      = sum_x >>> SHIFT;

    // Saturate to the signed output range, then apply optional ReLU.
    always_comb begin
        clip    = 1'b0;
        sat_val = rnd[OUT_W-1:0];
        if (rnd > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_W-1:0];
            clip    = 1'b1;
        end else if (rnd < OUT_MIN) begin
            sat_val = OUT_MIN[OUT_W-1:0];
            clip    = 1'b1;
        end
        out_val = sat_val;
        if ((RELU_EN != 0) && sat_val[OUT_W-1]) out_val = '0;
    end

    // Window FSM: next state, accumulator, counter and output register update.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        sat_d     = sat_q;
        if (accept) begin
            state_d = ST_ACCUM;
            acc_d   = sum;
            cnt_d   = (state_q == ST_FIRST) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            if (s_last) begin
                state_d   = ST_FIRST;
                acc_d     = '0;
                cnt_d     = '0;
                m_data_d  = out_val;
                m_valid_d = 1'b1;
                sat_d     = sat_q || clip;
            end
        end
    end

    // State registers; reset drops any partial window.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= ST_FIRST;
            acc_q     <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            sat_q     <= sat_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign beat_cnt = cnt_q;
    assign sat_flag = sat_q;

endmodule
